router_sync_n: RTL and testbench

- Parametrised synchroniser between the router FSM, register block and NUM_CH output FIFOs.
- Latches the destination address on each header and steers the write enable to that FIFO.
- Muxes the addressed FIFO's full flag back to the FSM.
- Drives valid-out to each output port, and raises a per-channel soft reset when a valid channel is not read within TIMEOUT cycles.
- New in this generation: configurable channel count and timeout, an explicit destination-valid state, a registered address-error pulse, and a soft reset that is held until cleared.

---
 rtl/router_pkg.sv | 32 +++
 rtl/router_sync_timer.sv | 56 +++++
 rtl/router_sync_n.sv | 90 +++++++++
 tb/tb_router_sync_n.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser slice.
//   - Default channel count, address width and timeout.
//   - clog2 helper used to size the timeout counters.
//   - CH_NONE: the channel index shown in debug views when no legal destination is latched.
//   - tmr_state_e: per-channel timeout state (counting / soft reset held).
package router_pkg;

    localparam int unsigned DEF_NUM_CH  = 3;
    localparam int unsigned DEF_ADDR_W  = 2;
    localparam int unsigned DEF_TIMEOUT = 30;

    // Channel indices run 0..15, so 16 can never name a real channel.
    localparam int unsigned CH_NONE = 16;

    typedef enum logic {
        TMR_COUNT,
        TMR_SRST
    } tmr_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One channel's unread-data watchdog.
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   vld        in   channel holds data (FIFO not empty)
//   rd         in   channel is being read this cycle
//   soft_reset out  raised on the TIMEOUT-th consecutive unread-valid edge,
//                   held until an edge sees the channel empty or read
module router_sync_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int unsigned     CNT_W = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    tmr_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= TMR_COUNT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Clear wins over expiry: a read on the expiring edge only restarts the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!vld || rd) begin
            state_nxt = TMR_COUNT;
            cnt_nxt   = '0;
        end else if (state == TMR_COUNT) begin
            if (cnt == LAST) begin
                state_nxt = TMR_SRST;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    assign soft_reset = (state == TMR_SRST);

endmodule

// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM, register block and NUM_CH output FIFOs.
// Ports:
//   clock, resetn   system clock (rising edge) / asynchronous active-low reset
//   detect_add      header strobe; data_in is latched as destination on this edge
//   data_in         destination address field of the header
//   write_enb_reg   FSM request to write the current byte
//   read_enb        per-channel read enable from the output side
//   empty, full     per-FIFO status flags
//   vld_out         per-channel data-valid (~empty)
//   write_enb       one-hot write enable to the latched destination FIFO
//   fifo_full       full flag of the latched destination FIFO
//   soft_reset      per-FIFO soft reset from the unread-data watchdogs
//   dest_valid      a legal destination is latched
//   addr_err        one-cycle pulse after a header with an illegal address
module router_sync_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              dest_valid,
    output logic              addr_err
);

    logic [ADDR_W-1:0] dest;
    logic              addr_legal;

    assign addr_legal = (32'(data_in) < NUM_CH);

    // An illegal header invalidates the destination but leaves dest itself untouched.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dest       <= '0;
            dest_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (detect_add) begin
                if (addr_legal) begin
                    dest       <= data_in;
                    dest_valid <= 1'b1;
                end else begin
                    dest_valid <= 1'b0;
                    addr_err   <= 1'b1;
                end
            end
        end
    end

    // Compare against each channel index rather than indexing by dest, so
    // ADDR_W may be wider than the index range of the channel vectors.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (dest_valid && (dest == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
module tb_router_sync_n;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    // Instance A: default parameters (3 channels, timeout 30)
    logic       a_detect, a_wer;
    logic [1:0] a_din;
    logic [2:0] a_rd, a_empty, a_full;
    logic [2:0] a_vld, a_we, a_sr;
    logic       a_ff, a_dv, a_err;

    // Instance B: 8 channels, 3-bit address, timeout 4
    logic       b_detect, b_wer;
    logic [2:0] b_din;
    logic [7:0] b_rd, b_empty, b_full;
    logic [7:0] b_vld, b_we, b_sr;
    logic       b_ff, b_dv, b_err;

    router_sync_n dut_a (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (a_detect),
        .data_in       (a_din),
        .write_enb_reg (a_wer),
        .read_enb      (a_rd),
        .empty         (a_empty),
        .full          (a_full),
        .vld_out       (a_vld),
        .write_enb     (a_we),
        .fifo_full     (a_ff),
        .soft_reset    (a_sr),
        .dest_valid    (a_dv),
        .addr_err      (a_err)
    );

    router_sync_n #(
        .NUM_CH  (8),
        .ADDR_W  (3),
        .TIMEOUT (4)
    ) dut_b (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (b_detect),
        .data_in       (b_din),
        .write_enb_reg (b_wer),
        .read_enb      (b_rd),
        .empty         (b_empty),
        .full          (b_full),
        .vld_out       (b_vld),
        .write_enb     (b_we),
        .fifo_full     (b_ff),
        .soft_reset    (b_sr),
        .dest_valid    (b_dv),
        .addr_err      (b_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per instance k, the run length of consecutive
    // unread-valid edges per channel, the soft-reset flag, and the latched header.
    int m_run [2][16];
    bit m_sr  [2][16];
    int m_dest[2];
    bit m_dv  [2];
    bit m_err [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_run[k][i] = 0;
                m_sr[k][i]  = 1'b0;
            end
            m_dest[k] = 0;
            m_dv[k]   = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic model_update(input int k, input int nch, input int to,
                                input logic [15:0] emp, input logic [15:0] rd,
                                input logic det, input int din);
        for (int i = 0; i < nch; i++) begin
            if (emp[i] || rd[i]) begin
                m_run[k][i] = 0;
                m_sr[k][i]  = 1'b0;
            end else if (!m_sr[k][i]) begin
                m_run[k][i] = m_run[k][i] + 1;
                if (m_run[k][i] == to) begin
                    m_sr[k][i]  = 1'b1;
                    m_run[k][i] = 0;
                end
            end
        end
        m_err[k] = 1'b0;
        if (det) begin
            if (din < nch) begin
                m_dest[k] = din;
                m_dv[k]   = 1'b1;
            end else begin
                m_dv[k]  = 1'b0;
                m_err[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_sr(input int k, input int nch);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nch; i++) v[i] = m_sr[k][i];
        return v;
    endfunction

    task automatic check_all();
        logic [2:0]  ea;
        logic [7:0]  eb;
        logic [31:0] we_a, we_b;
        ea = ~a_empty;
        eb = ~b_empty;
        we_a = (m_dv[0] && a_wer) ? (32'd1 << m_dest[0]) : 32'd0;
        we_b = (m_dv[1] && b_wer) ? (32'd1 << m_dest[1]) : 32'd0;
        check("a_vld_out", 32'(a_vld), 32'(ea));
        check("a_write_enb", 32'(a_we), we_a);
        check("a_fifo_full", 32'(a_ff), m_dv[0] ? 32'(a_full[m_dest[0]]) : 32'd0);
        check("a_soft_reset", 32'(a_sr), exp_sr(0, 3));
        check("a_dest_valid", 32'(a_dv), 32'(m_dv[0]));
        check("a_addr_err", 32'(a_err), 32'(m_err[0]));
        check("b_vld_out", 32'(b_vld), 32'(eb));
        check("b_write_enb", 32'(b_we), we_b);
        check("b_fifo_full", 32'(b_ff), m_dv[1] ? 32'(b_full[m_dest[1]]) : 32'd0);
        check("b_soft_reset", 32'(b_sr), exp_sr(1, 8));
        check("b_dest_valid", 32'(b_dv), 32'(m_dv[1]));
        check("b_addr_err", 32'(b_err), 32'(m_err[1]));
    endtask

    // Advance one edge, update the model with the inputs the DUT sampled, check 1 time unit later.
    task automatic tick();
        @(posedge clock);
        if (!resetn) begin
            model_reset();
        end else begin
            model_update(0, 3, 30, {13'b0, a_empty}, {13'b0, a_rd}, a_detect, int'(a_din));
            model_update(1, 8, 4, {8'b0, b_empty}, {8'b0, b_rd}, b_detect, int'(b_din));
        end
        #1;
        check_all();
    endtask

    initial begin
        a_detect = 1'b0; a_wer = 1'b0; a_din = '0; a_rd = '0; a_empty = '1; a_full = '0;
        b_detect = 1'b0; b_wer = 1'b0; b_din = '0; b_rd = '0; b_empty = '1; b_full = '0;
        model_reset();

        // Reset state
        #2;
        check_all();
        #10 resetn = 1'b1;
        tick();

        // Steering to channel 2; outputs follow from the cycle after detect_add
        a_detect = 1'b1; a_din = 2'd2; a_wer = 1'b1; a_full = 3'b100;
        #1;
        check("steer_we_before", 32'(a_we), 32'd0);
        tick();
        check("steer_we", 32'(a_we), 32'h4);
        check("steer_ff", 32'(a_ff), 32'd1);
        check("steer_dv", 32'(a_dv), 32'd1);
        a_din = 2'd0;
        #1;
        check("latency_old_dest", 32'(a_we), 32'h4);
        tick();
        check("latency_new_dest", 32'(a_we), 32'h1);

        // Illegal header
        a_din = 2'd3;
        tick();
        check("illegal_err", 32'(a_err), 32'd1);
        check("illegal_dv", 32'(a_dv), 32'd0);
        check("illegal_we", 32'(a_we), 32'd0);
        check("illegal_ff", 32'(a_ff), 32'd0);
        a_detect = 1'b0;
        tick();
        check("illegal_err_pulse", 32'(a_err), 32'd0);
        a_detect = 1'b1;
        tick();
        tick();
        check("illegal_err_back2back", 32'(a_err), 32'd1);
        a_detect = 1'b0;
        tick();

        // Timeout on channel 1
        a_empty = 3'b111;
        tick();
        a_empty = 3'b101;
        repeat (29) tick();
        check("timeout_edge29", 32'(a_sr), 32'd0);
        tick();
        check("timeout_edge30", 32'(a_sr), 32'h2);
        repeat (3) tick();
        check("timeout_hold", 32'(a_sr), 32'h2);
        a_empty = 3'b111;
        tick();
        check("timeout_clear", 32'(a_sr), 32'd0);

        // Rescue read on channel 0 at the expiring edge
        a_empty = 3'b110;
        repeat (29) tick();
        a_rd = 3'b001;
        tick();
        check("rescue_no_sr", 32'(a_sr), 32'd0);
        a_rd = 3'b000;
        repeat (29) tick();
        check("rescue_restart29", 32'(a_sr), 32'd0);
        tick();
        check("rescue_restart30", 32'(a_sr), 32'h1);
        a_empty = 3'b111;
        tick();

        // Asynchronous reset mid-run
        a_detect = 1'b1; a_din = 2'd1; a_wer = 1'b1; a_empty = 3'b101; a_full = 3'b010;
        tick();
        a_detect = 1'b0;
        tick();
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_ff", 32'(a_ff), 32'd0);
        check("rst_sr", 32'(a_sr), 32'd0);
        check("rst_dv", 32'(a_dv), 32'd0);
        check("rst_vld", 32'(a_vld), 32'h2);
        #2 resetn = 1'b1;
        tick();
        check("post_rst_we", 32'(a_we), 32'd0);
        a_empty = 3'b111; a_wer = 1'b0;

        // 8-channel instance, timeout 4
        b_detect = 1'b1; b_din = 3'd7; b_wer = 1'b1;
        tick();
        b_detect = 1'b0;
        check("sweep_we", 32'(b_we), 32'h80);
        b_empty = 8'h7F;
        repeat (3) tick();
        check("sweep_sr_pre", 32'(b_sr), 32'd0);
        tick();
        check("sweep_sr", 32'(b_sr), 32'h80);
        b_empty = 8'hFF;
        tick();

        // Randomised traffic on both instances
        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                a_empty[i] = ($urandom_range(0, 19) == 0);
                a_rd[i]    = ($urandom_range(0, 29) == 0);
            end
            for (int i = 0; i < 8; i++) begin
                b_empty[i] = ($urandom_range(0, 5) == 0);
                b_rd[i]    = ($urandom_range(0, 5) == 0);
            end
            a_detect = ($urandom_range(0, 3) == 0);
            a_din    = 2'($urandom);
            a_wer    = 1'($urandom);
            a_full   = 3'($urandom);
            b_detect = ($urandom_range(0, 3) == 0);
            b_din    = 3'($urandom);
            b_wer    = 1'($urandom);
            b_full   = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
